// File: rtl/rot_cmd_queue.sv
// Command queue feeding an 8-bit barrel rotator, with a registered valid/ready result stage.
// Latency: a command pushed into an empty queue with a free output appears on out_* one edge later.
// Backpressure: out_ready low holds out_*, the FIFO fills to DEPTH, then in_ready drops (no full-bypass).
module rot_cmd_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [7:0]    in_data,
   input  logic          in_lr,
   input  logic [2:0]    in_amount,
   output logic [7:0]    rot_data,
   output logic          rot_lr,
   output logic [2:0]    rot_amount,
   input  logic [7:0]    rot_result,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [7:0]    out_data,
   output logic          out_lr,
   output logic [2:0]    out_amount,
   output logic [AW:0]   count
);

   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   // Entry layout: {data[11:4], lr[3], amount[2:0]}
   logic [11:0]   r_mem [DEPTH];
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;
   logic          r_out_valid;
   logic [7:0]    r_out_data;
   logic          r_out_lr;
   logic [2:0]    r_out_amount;

   logic          w_empty;
   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic [11:0]   w_head;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   // Flush wins over both handshakes in its cycle.
   assign w_push  = in_valid & ~w_full & ~flush;
   assign w_pop   = ~w_empty & (~r_out_valid | out_ready) & ~flush;

   assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

   // Head of queue drives the rotator; forced to zero when there is nothing queued.
   assign rot_data   = w_empty ? 8'd0 : w_head[11:4];
   assign rot_lr     = w_empty ? 1'b0 : w_head[3];
   assign rot_amount = w_empty ? 3'd0 : w_head[2:0];

   assign in_ready   = ~w_full;
   assign count      = r_wr_ptr - r_rd_ptr;
   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign out_lr     = r_out_lr;
   assign out_amount = r_out_amount;

   // Command storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {in_data, in_lr, in_amount};
      end
   end

   // Read/write pointers, wrapping mod 2*DEPTH through natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   // Result register: capture the rotator output on pop, drop valid once consumed with nothing behind it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= 8'd0;
         r_out_lr     <= 1'b0;
         r_out_amount <= 3'd0;
      end else if (flush) begin
         r_out_valid  <= 1'b0;
      end else if (w_pop) begin
         r_out_valid  <= 1'b1;
         r_out_data   <= rot_result;
         r_out_lr     <= rot_lr;
         r_out_amount <= rot_amount;
      end else if (r_out_valid && out_ready) begin
         r_out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rot_cmd_queue.sv
// Self-checking bench for rot_cmd_queue with a behavioural rotator on rot_*/rot_result.
// A queue-based reference model is compared against the DUT on every falling edge.
// Directed scenarios pin the model with hand-computed literal results.
module tb_rot_cmd_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    in_data;
   logic          in_lr;
   logic [2:0]    in_amount;
   logic [7:0]    rot_data;
   logic          rot_lr;
   logic [2:0]    rot_amount;
   logic [7:0]    rot_result;
   logic          out_valid;
   logic          out_ready;
   logic [7:0]    out_data;
   logic          out_lr;
   logic [2:0]    out_amount;
   logic [AW:0]   count;

   int n_tests = 0;
   int n_fail  = 0;

   rot_cmd_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_lr      (in_lr),
      .in_amount  (in_amount),
      .rot_data   (rot_data),
      .rot_lr     (rot_lr),
      .rot_amount (rot_amount),
      .rot_result (rot_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_lr     (out_lr),
      .out_amount (out_amount),
      .count      (count)
   );

   // Downstream barrel rotator.
   logic [15:0] w_dd;
   logic [15:0] w_sh;
   assign w_dd = {rot_data, rot_data};
   assign w_sh = rot_lr ? (w_dd >> (4'd8 - {1'b0, rot_amount})) : (w_dd >> rot_amount);
   assign rot_result = w_sh[7:0];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference rotation: a right rotate by a is a left rotate by (8-a) mod 8.
   function automatic logic [7:0] ref_rot(input logic [7:0] d, input logic lr, input logic [2:0] a);
      int          sh;
      logic [15:0] w;
      sh = lr ? int'(a) : (8 - int'(a)) % 8;
      w  = {8'd0, d} << sh;
      return w[7:0] | w[15:8];
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [11:0] m_q[$];
   logic        m_ov   = 1'b0;
   logic [7:0]  m_od   = 8'd0;
   logic        m_olr  = 1'b0;
   logic [2:0]  m_oamt = 3'd0;

   always @(negedge rst_n) begin
      m_q.delete();
      m_ov = 1'b0; m_od = 8'd0; m_olr = 1'b0; m_oamt = 3'd0;
   end

   always @(posedge clk) begin
      if (rst_n) begin
         if (flush) begin
            m_q.delete();
            m_ov = 1'b0;
         end else begin
            logic        do_pop, do_push;
            logic [11:0] c;
            do_pop  = (m_q.size() > 0) && (!m_ov || out_ready);
            do_push = in_valid && (m_q.size() < DEPTH);
            if (do_pop) begin
               c      = m_q.pop_front();
               m_od   = ref_rot(c[11:4], c[3], c[2:0]);
               m_olr  = c[3];
               m_oamt = c[2:0];
               m_ov   = 1'b1;
            end else if (m_ov && out_ready) begin
               m_ov = 1'b0;
            end
            if (do_push) m_q.push_back({in_data, in_lr, in_amount});
         end
      end
   end

   // ---------------- per-cycle compare + result collection ----------------
   logic [7:0] got[$];

   always @(negedge clk) begin
      if (rst_n) begin
         logic [11:0] h;
         h = (m_q.size() > 0) ? m_q[0] : 12'd0;
         chk("count",      int'(count),      m_q.size());
         chk("in_ready",   int'(in_ready),   (m_q.size() < DEPTH) ? 1 : 0);
         chk("out_valid",  int'(out_valid),  int'(m_ov));
         chk("out_data",   int'(out_data),   int'(m_od));
         chk("out_lr",     int'(out_lr),     int'(m_olr));
         chk("out_amount", int'(out_amount), int'(m_oamt));
         chk("rot_data",   int'(rot_data),   int'(h[11:4]));
         chk("rot_lr",     int'(rot_lr),     int'(h[3]));
         chk("rot_amount", int'(rot_amount), int'(h[2:0]));
         if (out_valid && out_ready) got.push_back(out_data);
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [7:0] d, input logic lr, input logic [2:0] a);
      int n;
      in_valid  = 1'b1;
      in_data   = d;
      in_lr     = lr;
      in_amount = a;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 100);
      if (!in_ready) chk("send_timeout", int'(in_ready), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic chk_got(input string nm, input logic [7:0] exp[$]);
      chk({nm, "_len"}, got.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         chk(nm, int'(got[i]), int'(exp[i]));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp_q[$];
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'd0;
      in_lr = 1'b0; in_amount = 3'd0; out_ready = 1'b0;
      #22;
      chk("rst_count",     int'(count),     0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_in_ready",  int'(in_ready),  1);
      chk("rst_out_data",  int'(out_data),  0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single command: 10010010 rotated left by 3.
      out_ready = 1'b1;
      send(8'b10010010, 1'b1, 3'd3);
      @(negedge clk);
      chk("single_not_yet", int'(out_valid), 0);
      chk("single_rot_data", int'(rot_data), 8'h92);
      @(negedge clk);
      chk("single_valid",  int'(out_valid),  1);
      chk("single_data",   int'(out_data),   8'b10010100);
      chk("single_lr",     int'(out_lr),     1);
      chk("single_amount", int'(out_amount), 3);
      @(posedge clk); #1;

      // Stream: right rotations by 0..7 back to back.
      got.delete();
      for (int i = 0; i < 8; i++) send(8'h92, 1'b0, 3'(i));
      repeat (4) @(posedge clk);
      #1;
      exp_q = '{8'h92, 8'h49, 8'hA4, 8'h52, 8'h29, 8'h94, 8'h4A, 8'h25};
      chk_got("stream", exp_q);

      // Backpressure: five pushes with the consumer stalled.
      got.delete();
      out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) send(8'h01, 1'b1, 3'(i));
      in_valid = 1'b1; in_data = 8'h80; in_lr = 1'b1; in_amount = 3'd1;
      repeat (3) begin
         @(negedge clk);
         chk("bp_count",    int'(count),     4);
         chk("bp_in_ready", int'(in_ready),  0);
         chk("bp_out_data", int'(out_data),  8'h02);
         chk("bp_out_vld",  int'(out_valid), 1);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      begin
         int n;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!in_ready && n < 100);
         if (!in_ready) chk("bp_timeout", int'(in_ready), 1);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      exp_q = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h01};
      chk_got("drain", exp_q);

      // Simultaneous push and pop at count = 2.
      out_ready = 1'b0;
      send(8'h0F, 1'b1, 3'd1);
      send(8'h0F, 1'b1, 3'd2);
      send(8'h0F, 1'b1, 3'd3);
      @(negedge clk);
      chk("pp_pre_count", int'(count),    2);
      chk("pp_pre_data",  int'(out_data), 8'h1E);
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 8'h0F; in_lr = 1'b1; in_amount = 3'd4;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk("pp_count", int'(count),    2);
      chk("pp_data",  int'(out_data), 8'h3C);

      // Flush at count = 3 with a push offered in the same cycle.
      @(posedge clk); #1;
      send(8'h0F, 1'b1, 3'd5);
      @(negedge clk);
      chk("fl_pre_count", int'(count),     3);
      chk("fl_pre_vld",   int'(out_valid), 1);
      @(posedge clk); #1;
      flush = 1'b1; in_valid = 1'b1; in_data = 8'h55; in_lr = 1'b0; in_amount = 3'd1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("fl_count",    int'(count),     0);
      chk("fl_out_vld",  int'(out_valid), 0);
      chk("fl_in_ready", int'(in_ready),  1);
      chk("fl_out_data", int'(out_data),  8'h3C);

      // Asynchronous reset between edges with work in flight.
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(8'h11, 1'b0, 3'd1);
      send(8'h22, 1'b0, 3'd2);
      send(8'h33, 1'b0, 3'd3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", int'(out_valid), 0);
      chk("arst_count",     int'(count),     0);
      chk("arst_out_data",  int'(out_data),  0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(8'hA5, 1'b1, 3'd4);
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_valid", int'(out_valid), 1);
      chk("post_rst_data",  int'(out_data),  8'h5A);
      repeat (3) @(posedge clk);
      #1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
